// File: rtl/munoc_txn_observer_pkg.sv
// Shared constants for the transaction observer: default sizing and the
// bit positions of the sticky error vector.
package munoc_txn_observer_pkg;

    localparam int BW_LEN_DEFAULT = 8;
    localparam int DEPTH_DEFAULT  = 4;

    localparam int NUM_ERR        = 5;
    localparam int ERR_ORPHAN     = 0;
    localparam int ERR_LAST_EARLY = 1;
    localparam int ERR_LAST_LATE  = 2;
    localparam int ERR_OVERFLOW   = 3;
    localparam int ERR_UNSTABLE   = 4;

endpackage

// File: rtl/munoc_len_fifo.sv
// Burst-length FIFO. A push is accepted when not full, or when full with a
// pop in the same cycle; a pop on an empty FIFO is ignored.
module munoc_len_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Occupancy flags come straight from the registered count.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rd_ptr];
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/munoc_txn_observer.sv
// Passive observer of a request/response-burst link: tracks outstanding
// burst lengths, pulses on request acceptance and burst completion, and
// latches protocol errors until cleared.
module munoc_txn_observer
    import munoc_txn_observer_pkg::*;
#(
    parameter int BW_LEN = BW_LEN_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req_valid,
    input  logic              req_ready,
    input  logic [BW_LEN-1:0] req_len,
    input  logic              rsp_valid,
    input  logic              rsp_ready,
    input  logic              rsp_last,
    input  logic              err_clear,
    output logic              txn_up,
    output logic              txn_down,
    output logic              fifo_full,
    output logic [BW_LEN-1:0] beat_count,
    output logic              err_orphan,
    output logic              err_last_early,
    output logic              err_last_late,
    output logic              err_overflow,
    output logic              err_unstable,
    output logic              err_any
);

    logic              req_acc;
    logic              beat;
    logic              fifo_empty;
    logic              fifo_full_w;
    logic [BW_LEN-1:0] head_len;
    logic              at_head;
    logic              pop;
    logic [NUM_ERR-1:0] err_event;
    logic [NUM_ERR-1:0] err_q;
    logic [BW_LEN-1:0] beat_count_q;
    logic              stall_q;
    logic [BW_LEN-1:0] stall_len_q;
    logic              txn_up_q;
    logic              txn_down_q;

    munoc_len_fifo #(
        .WIDTH (BW_LEN),
        .DEPTH (DEPTH)
    ) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_acc),
        .pop       (pop),
        .push_data (req_len),
        .head      (head_len),
        .full      (fifo_full_w),
        .empty     (fifo_empty)
    );

    // Classify this cycle's handshakes; a burst ends on rsp_last or on the
    // expected final beat, whichever comes first.
    always_comb begin
        req_acc   = enable & req_valid & req_ready;
        beat      = enable & rsp_valid & rsp_ready;
        at_head   = (beat_count_q == head_len);
        pop       = beat & ~fifo_empty & (rsp_last | at_head);
        err_event = '0;
        err_event[ERR_ORPHAN]     = beat & fifo_empty;
        err_event[ERR_LAST_EARLY] = beat & ~fifo_empty & rsp_last & ~at_head;
        err_event[ERR_LAST_LATE]  = beat & ~fifo_empty & ~rsp_last & at_head;
        err_event[ERR_OVERFLOW]   = req_acc & fifo_full_w & ~pop;
        err_event[ERR_UNSTABLE]   = enable & stall_q &
                                    (~req_valid | (req_len != stall_len_q));
    end

    // Beat counter within the burst at the FIFO head.
    always_ff @(posedge clk) begin
        if (rst)                       beat_count_q <= '0;
        else if (pop)                  beat_count_q <= '0;
        else if (beat && !fifo_empty)  beat_count_q <= beat_count_q + BW_LEN'(1);
    end

    // Registered event pulses; both go quiet when enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_up_q   <= 1'b0;
            txn_down_q <= 1'b0;
        end else begin
            txn_up_q   <= req_acc;
            txn_down_q <= pop;
        end
    end

    // Remember a stalled request so the next enabled cycle can be checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q     <= 1'b0;
            stall_len_q <= '0;
        end else begin
            stall_q     <= enable & req_valid & ~req_ready;
            stall_len_q <= req_len;
        end
    end

    // Sticky errors; a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= ((enable & err_clear) ? '0 : err_q) | err_event;
    end

    assign txn_up         = txn_up_q;
    assign txn_down       = txn_down_q;
    assign fifo_full      = fifo_full_w;
    assign beat_count     = beat_count_q;
    assign err_orphan     = err_q[ERR_ORPHAN];
    assign err_last_early = err_q[ERR_LAST_EARLY];
    assign err_last_late  = err_q[ERR_LAST_LATE];
    assign err_overflow   = err_q[ERR_OVERFLOW];
    assign err_unstable   = err_q[ERR_UNSTABLE];
    assign err_any        = |err_q;

endmodule

// File: tb/tb_munoc_txn_observer.sv
// Bench for the transaction observer: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_munoc_txn_observer;
    import munoc_txn_observer_pkg::*;

    localparam int BW_LEN = 8;
    localparam int DEPTH  = 4;
    localparam int VW     = BW_LEN + 9;

    logic              clk = 1'b0;
    logic              rst, enable, req_valid, req_ready;
    logic [BW_LEN-1:0] req_len;
    logic              rsp_valid, rsp_ready, rsp_last, err_clear;
    logic              txn_up, txn_down, fifo_full;
    logic [BW_LEN-1:0] beat_count;
    logic              err_orphan, err_last_early, err_last_late;
    logic              err_overflow, err_unstable, err_any;

    int tests = 0;
    int fails = 0;

    logic [VW-1:0] exp_q[$];

    int       m_q[$];
    int       m_beats;
    bit [4:0] m_err;
    bit       m_hist;
    int       m_hist_len;

    munoc_txn_observer #(.BW_LEN(BW_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_last(rsp_last),
        .err_clear(err_clear),
        .txn_up(txn_up), .txn_down(txn_down), .fifo_full(fifo_full),
        .beat_count(beat_count),
        .err_orphan(err_orphan), .err_last_early(err_last_early),
        .err_last_late(err_last_late), .err_overflow(err_overflow),
        .err_unstable(err_unstable), .err_any(err_any)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding bursts as a queue of lengths.
    task automatic model_step();
        bit up, bt, down, full_pre;
        bit [4:0] ev;
        int h;
        ev = '0;
        down = 1'b0;
        if (rst) begin
            m_q.delete();
            m_beats = 0;
            m_err = '0;
            m_hist = 1'b0;
            m_hist_len = 0;
            exp_q.push_back('0);
            return;
        end
        up = enable && req_valid && req_ready;
        bt = enable && rsp_valid && rsp_ready;
        full_pre = (m_q.size() == DEPTH);
        if (bt) begin
            if (m_q.size() == 0) begin
                ev[ERR_ORPHAN] = 1'b1;
            end else begin
                h = m_q[0];
                if (m_beats == h) begin
                    if (!rsp_last) ev[ERR_LAST_LATE] = 1'b1;
                    down = 1'b1;
                end else if (rsp_last) begin
                    ev[ERR_LAST_EARLY] = 1'b1;
                    down = 1'b1;
                end else begin
                    m_beats++;
                end
            end
        end
        if (down) begin
            void'(m_q.pop_front());
            m_beats = 0;
        end
        if (up) begin
            if (full_pre && !down) ev[ERR_OVERFLOW] = 1'b1;
            else m_q.push_back(int'(req_len));
        end
        if (enable && m_hist && (!req_valid || int'(req_len) != m_hist_len))
            ev[ERR_UNSTABLE] = 1'b1;
        m_hist = enable && req_valid && !req_ready;
        m_hist_len = int'(req_len);
        if (enable && err_clear) m_err = '0;
        m_err |= ev;
        exp_q.push_back({up, down, (m_q.size() == DEPTH), m_beats[BW_LEN-1:0],
                         m_err, |m_err});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare the DUT's registered outputs against the model.
    initial begin
        logic [VW-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {txn_up, txn_down, fifo_full, beat_count, err_unstable,
                         err_overflow, err_last_late, err_last_early, err_orphan,
                         err_any};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL scoreboard @%0t: got %h expected %h", $time, act_v, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; enable = 1; req_valid = 0; req_ready = 0; req_len = '0;
        rsp_valid = 0; rsp_ready = 0; rsp_last = 0; err_clear = 0;
    endtask

    task automatic send_req(input int len);
        req_valid = 1; req_ready = 1; req_len = BW_LEN'(len);
    endtask

    task automatic send_beat(input bit last);
        rsp_valid = 1; rsp_ready = 1; rsp_last = last;
    endtask

    initial begin
        int ups;
        bit stalled;
        idle();
        rst = 1;
        step(); step();
        chk("reset_outputs", {txn_up, txn_down, fifo_full, beat_count, err_any}, 0);
        idle();
        step();

        // Normal burst: len=3, four beats.
        send_req(3); step();
        chk("s1_txn_up", txn_up, 1);
        idle(); step();
        chk("s1_txn_up_once", txn_up, 0);
        for (int i = 0; i < 4; i++) begin
            send_beat(i == 3); step();
            if (i < 3) begin
                chk("s1_beat_count", beat_count, i + 1);
                chk("s1_no_down", txn_down, 0);
            end else begin
                chk("s1_txn_down", txn_down, 1);
                chk("s1_count_zero", beat_count, 0);
            end
        end
        idle(); step();
        chk("s1_down_once", txn_down, 0);
        chk("s1_no_err", err_any, 0);

        // Orphan beat, then clear.
        send_beat(1); step();
        chk("s2_orphan", err_orphan, 1);
        chk("s2_any", err_any, 1);
        idle(); err_clear = 1; step();
        chk("s2_orphan_clr", err_orphan, 0);
        chk("s2_any_clr", err_any, 0);
        idle();

        // Early last on beat 2 of a 3-beat burst.
        send_req(2); step();
        idle(); send_beat(0); step();
        chk("s3_count1", beat_count, 1);
        send_beat(1); step();
        chk("s3_early", err_last_early, 1);
        chk("s3_down", txn_down, 1);
        chk("s3_count0", beat_count, 0);
        idle(); err_clear = 1; step();
        idle();

        // Overflow: five requests into a four-entry FIFO.
        ups = 0;
        for (int i = 0; i < 5; i++) begin
            send_req(0); step();
            ups += int'(txn_up);
            if (i == 3) begin
                chk("s4_full", fifo_full, 1);
                chk("s4_no_ovf_yet", err_overflow, 0);
            end
        end
        chk("s4_overflow", err_overflow, 1);
        idle(); step();
        ups += int'(txn_up);
        chk("s4_up_count", ups, 5);
        for (int i = 0; i < 4; i++) begin
            send_beat(1); step();
        end
        idle(); err_clear = 1; step();
        chk("s4_drained", {fifo_full, err_any}, 0);
        idle();

        // Unstable stalled request.
        req_valid = 1; req_ready = 0; req_len = 5; step();
        req_len = 6; step();
        chk("s5_unstable", err_unstable, 1);
        idle(); rst = 1; step();
        chk("s5_reset", {txn_up, txn_down, fifo_full, beat_count, err_any}, 0);
        idle();

        // Reset mid-burst, then a clean single-beat burst.
        send_req(7); step();
        idle(); send_beat(0); step(); step();
        chk("s6_count2", beat_count, 2);
        idle(); rst = 1; step();
        chk("s6_rst_count", beat_count, 0);
        chk("s6_rst_out", {txn_up, txn_down, fifo_full, err_any}, 0);
        idle(); step();
        chk("s6_no_down", txn_down, 0);
        send_req(0); step();
        idle(); send_beat(1); step();
        chk("s6_down", txn_down, 1);
        chk("s6_clean", {err_any, beat_count}, 0);
        idle(); step();

        // Random traffic.
        stalled = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if (stalled && $urandom_range(0, 19) != 0) begin
                req_valid = 1;
            end else begin
                req_valid = ($urandom_range(0, 2) == 0);
                req_len = BW_LEN'($urandom_range(0, 3));
            end
            req_ready = ($urandom_range(0, 2) != 0);
            rsp_valid = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rsp_last = ($urandom_range(0, 2) == 0);
            err_clear = enable && ($urandom_range(0, 29) == 0);
            stalled = enable && req_valid && !req_ready && !rst;
            step();
        end

        idle(); step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
